bcd_scheduler: RTL and testbench

Sequential binary-to-BCD conversion scheduler feeding the seven-segment display block. It shares one shift-add-3 (double-dabble) engine between three measurement requesters: the frequency meter, the high-resolution DDS frequency and the duty-cycle meter. This replaces per-source combinational divide/modulo chains. Each channel's latest 8-digit BCD result is held in a register for the display multiplexer to read.

---
 rtl/bcd_sched_pkg.sv | 38 +++
 rtl/bcd_dabble_core.sv | 63 ++++++
 rtl/bcd_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_bcd_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared definitions for the BCD conversion scheduler.
// Contents: FSM state enum, channel indices, the largest decimal value that
// fits in eight BCD digits, and helper functions that size the accumulator
// and compute the saturation threshold for arbitrary DIGITS.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2
  } bcd_state_e;

  localparam int CH_FREQ = 0;
  localparam int CH_HRES = 1;
  localparam int CH_DUTY = 2;
  localparam int NUM_CH  = 3;

  localparam longint unsigned MAX_DEC = 64'd99_999_999;

  // 10^digits - 1, the largest value representable in 'digits' BCD digits.
  function automatic logic [63:0] max_dec(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  // Accumulator digits: enough for any DATA_W-bit value (0.3*W + 1 covers
  // log10(2^W) for realistic widths) and always at least one digit above
  // the kept result so that an over-range value leaves a non-zero high digit.
  function automatic int acc_digits(input int data_w, input int digits);
    int d;
    d = (data_w * 3) / 10 + 1;
    if (d < digits + 1) d = digits + 1;
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Shift-add-3 (double-dabble) binary-to-BCD datapath.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : copy load_val into the shifter, clear acc and cnt
//   load_val     : binary value to convert
//   run          : perform one add-3/shift step this cycle
//   acc          : BCD accumulator (valid after DATA_W run cycles)
//   last_shift   : high during the run cycle that performs the final shift
module bcd_dabble_core #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              run,
  output logic [ACC_W-1:0]  acc,
  output logic              last_shift
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int NIB   = ACC_W / 4;

  logic [ACC_W-1:0]  acc_q, acc_d, adj;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    adj   = acc_q;
    // Pre-correct every digit that would exceed 9 after doubling.
    for (int i = 0; i < NIB; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (load) begin
      acc_d = '0;
      sh_d  = load_val;
      cnt_d = '0;
    end else if (run) begin
      {acc_d, sh_d} = {adj, sh_q} << 1;
      cnt_d         = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc        = acc_q;
  assign last_shift = run && (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/bcd_scheduler.sv
// Shares one double-dabble engine between three requesters (freq, hres,
// duty) and holds each channel's latest packed BCD result for the display.
// Optional feature: define BCD_SCHED_RR_EN for round-robin arbitration;
// otherwise fixed priority freq > hres > duty.
// Ports:
//   freq_source            : clock
//   rst                    : asynchronous active-low reset
//   {freq,hres,duty}_valid : strobe sampling the matching *_data
//   {freq,hres,duty}_data  : binary value (duty is 16 bits, zero-extended)
//   {freq,hres,duty}_bcd   : packed BCD result, digit 0 in [3:0]
//   {freq,hres,duty}_done  : one-cycle pulse when that result updates
//   {freq,hres,duty}_ovf   : last converted value exceeded 10^DIGITS-1
//   busy                   : FSM not in IDLE
//   state_dbg              : current FSM state
// Handshake: a valid strobe is sampled on every rising edge with no ready;
// the newest value per channel wins and is converted when the engine frees.
module bcd_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                freq_source,
  input  logic                rst,
  input  logic                freq_valid,
  input  logic [DATA_W-1:0]   freq_data,
  input  logic                hres_valid,
  input  logic [DATA_W-1:0]   hres_data,
  input  logic                duty_valid,
  input  logic [15:0]         duty_data,
  output logic [4*DIGITS-1:0] freq_bcd,
  output logic [4*DIGITS-1:0] hres_bcd,
  output logic [4*DIGITS-1:0] duty_bcd,
  output logic                freq_done,
  output logic                hres_done,
  output logic                duty_done,
  output logic                freq_ovf,
  output logic                hres_ovf,
  output logic                duty_ovf,
  output logic                busy,
  output bcd_state_e          state_dbg
);

  localparam int          RES_W   = 4 * DIGITS;
  localparam int          ACC_W   = 4 * acc_digits(DATA_W, DIGITS);
  localparam logic [63:0] MAX_VAL = max_dec(DIGITS);

  logic [NUM_CH-1:0]             valid_vec;
  logic [NUM_CH-1:0][DATA_W-1:0] data_vec;

  bcd_state_e                    state_q, state_d;
  logic [1:0]                    grant_q, grant_d;
  logic                          sat_q, sat_d;
  logic [NUM_CH-1:0]             pending_q, pending_d;
  logic [NUM_CH-1:0][DATA_W-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0][RES_W-1:0]  res_q, res_d;
  logic [NUM_CH-1:0]             ovf_q, ovf_d;
  logic [NUM_CH-1:0]             done_q, done_d;

  logic [1:0]       pick;
  logic             core_load, core_run, last_shift;
  logic [ACC_W-1:0] acc;
  logic             over_range;

  assign valid_vec = {duty_valid, hres_valid, freq_valid};
  assign data_vec[CH_FREQ] = freq_data;
  assign data_vec[CH_HRES] = hres_data;
  assign data_vec[CH_DUTY] = DATA_W'(duty_data);

`ifdef BCD_SCHED_RR_EN
  logic [1:0] last_q, last_d;
  logic       found;

  // Search starts one past the last granted channel.
  always_comb begin
    pick  = 2'(CH_FREQ);
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!found && pending_q[(int'(last_q) + k) % NUM_CH]) begin
        pick  = 2'((int'(last_q) + k) % NUM_CH);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    if (pending_q[CH_FREQ])      pick = 2'(CH_FREQ);
    else if (pending_q[CH_HRES]) pick = 2'(CH_HRES);
    else                         pick = 2'(CH_DUTY);
  end
`endif

  // The grant-time compare catches every over-range value; non-zero high
  // digits in the accumulator can only occur alongside it.
  assign over_range = sat_q || (|acc[ACC_W-1:RES_W]);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sat_d     = sat_q;
    pending_d = pending_q;
    hold_d    = hold_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    done_d    = '0;
    core_load = 1'b0;
    core_run  = 1'b0;
`ifdef BCD_SCHED_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          core_load       = 1'b1;
          grant_d         = pick;
          sat_d           = 64'(hold_q[pick]) > MAX_VAL;
          pending_d[pick] = 1'b0;
          state_d         = CONV;
`ifdef BCD_SCHED_RR_EN
          last_d          = pick;
`endif
        end
      end
      CONV: begin
        core_run = 1'b1;
        if (last_shift) state_d = WRITE;
      end
      WRITE: begin
        res_d[grant_q]  = over_range ? {DIGITS{4'h9}} : acc[RES_W-1:0];
        ovf_d[grant_q]  = over_range;
        done_d[grant_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Captures after the grant clear so a same-cycle strobe keeps pending set.
    for (int c = 0; c < NUM_CH; c++) begin
      if (valid_vec[c]) begin
        hold_d[c]    = data_vec[c];
        pending_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge freq_source or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sat_q     <= 1'b0;
      pending_q <= '0;
      hold_q    <= '0;
      res_q     <= '0;
      ovf_q     <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sat_q     <= sat_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

`ifdef BCD_SCHED_RR_EN
  always_ff @(posedge freq_source or negedge rst) begin
    if (!rst) last_q <= 2'(CH_DUTY);
    else      last_q <= last_d;
  end
`endif

  bcd_dabble_core #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_core (
    .clk        (freq_source),
    .rst_n      (rst),
    .load       (core_load),
    .load_val   (hold_q[pick]),
    .run        (core_run),
    .acc        (acc),
    .last_shift (last_shift)
  );

  assign freq_bcd  = res_q[CH_FREQ];
  assign hres_bcd  = res_q[CH_HRES];
  assign duty_bcd  = res_q[CH_DUTY];
  assign freq_done = done_q[CH_FREQ];
  assign hres_done = done_q[CH_HRES];
  assign duty_done = done_q[CH_DUTY];
  assign freq_ovf  = ovf_q[CH_FREQ];
  assign hres_ovf  = ovf_q[CH_HRES];
  assign duty_ovf  = ovf_q[CH_DUTY];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_scheduler.sv
module tb_bcd_scheduler;

  localparam int DATA_W = 32;
  localparam int DIGITS = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              freq_valid = 1'b0, hres_valid = 1'b0, duty_valid = 1'b0;
  logic [DATA_W-1:0] freq_data = '0, hres_data = '0;
  logic [15:0]       duty_data = '0;
  logic [31:0]       freq_bcd, hres_bcd, duty_bcd;
  logic              freq_done, hres_done, duty_done;
  logic              freq_ovf, hres_ovf, duty_ovf, busy;
  bcd_sched_pkg::bcd_state_e state_dbg;

  bcd_scheduler #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .freq_source (clk),
    .rst         (rst_n),
    .freq_valid  (freq_valid),
    .freq_data   (freq_data),
    .hres_valid  (hres_valid),
    .hres_data   (hres_data),
    .duty_valid  (duty_valid),
    .duty_data   (duty_data),
    .freq_bcd    (freq_bcd),
    .hres_bcd    (hres_bcd),
    .duty_bcd    (duty_bcd),
    .freq_done   (freq_done),
    .hres_done   (hres_done),
    .duty_done   (duty_done),
    .freq_ovf    (freq_ovf),
    .hres_ovf    (hres_ovf),
    .duty_ovf    (duty_ovf),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Engine timeline: a grant starts a DATA_W+1 cycle countdown; when it
  // reaches zero the decimal result of the granted value is published.
  logic [31:0] m_hold [3] = '{default: '0};
  bit          m_pend [3] = '{default: 1'b0};
  logic [31:0] m_bcd  [3] = '{default: '0};
  bit          m_ovf  [3] = '{default: 1'b0};
  bit          m_done [3] = '{default: 1'b0};
  int          m_left = 0;
  int          m_ch   = 0;
  int          m_last = 2;
  logic [31:0] m_val  = '0;

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] x;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
`ifdef BCD_SCHED_RR_EN
      int idx = (m_last + 1 + k) % 3;
`else
      int idx = k;
`endif
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_hold[c] = '0; m_pend[c] = 0; m_bcd[c] = '0; m_ovf[c] = 0; m_done[c] = 0;
      end
      m_left = 0; m_ch = 0; m_last = 2; m_val = '0;
    end else begin
      int p;
      for (int c = 0; c < 3; c++) m_done[c] = 0;
      if (m_left == 0) begin
        p = model_pick();
        if (p >= 0) begin
          m_ch = p; m_val = m_hold[p]; m_pend[p] = 0; m_last = p;
          m_left = DATA_W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_bcd[m_ch]  = to_bcd(m_val);
          m_ovf[m_ch]  = (m_val > 32'd99_999_999);
          m_done[m_ch] = 1;
        end
      end
      if (freq_valid) begin m_hold[0] = freq_data;          m_pend[0] = 1; end
      if (hres_valid) begin m_hold[1] = hres_data;          m_pend[1] = 1; end
      if (duty_valid) begin m_hold[2] = 32'(duty_data);     m_pend[2] = 1; end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit run_chk = 1'b1;
  always @(negedge clk) begin
    if (run_chk) begin
      check("cyc_freq_bcd",  freq_bcd,  m_bcd[0]);
      check("cyc_hres_bcd",  hres_bcd,  m_bcd[1]);
      check("cyc_duty_bcd",  duty_bcd,  m_bcd[2]);
      check("cyc_freq_done", 32'(freq_done), 32'(m_done[0]));
      check("cyc_hres_done", 32'(hres_done), 32'(m_done[1]));
      check("cyc_duty_done", 32'(duty_done), 32'(m_done[2]));
      check("cyc_freq_ovf",  32'(freq_ovf),  32'(m_ovf[0]));
      check("cyc_hres_ovf",  32'(hres_ovf),  32'(m_ovf[1]));
      check("cyc_duty_ovf",  32'(duty_ovf),  32'(m_ovf[2]));
      check("cyc_busy",      32'(busy),      32'(m_left != 0));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic done_of(input int ch);
    case (ch)
      0:       return freq_done;
      1:       return hres_done;
      default: return duty_done;
    endcase
  endfunction

  // Strobe one channel for one cycle; returns #1 after the sampling edge.
  task automatic send(input int ch, input logic [31:0] d);
    @(negedge clk);
    case (ch)
      0:       begin freq_valid = 1'b1; freq_data = d; end
      1:       begin hres_valid = 1'b1; hres_data = d; end
      default: begin duty_valid = 1'b1; duty_data = d[15:0]; end
    endcase
    @(posedge clk);
    #1;
    freq_valid = 1'b0; hres_valid = 1'b0; duty_valid = 1'b0;
  endtask

  // Counts edges until the channel's done is seen; -1 if the budget expires.
  task automatic wait_done(input int ch, input int max, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max; k++) begin
      @(posedge clk);
      #1;
      if (done_of(ch)) begin
        cyc = k;
        break;
      end
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c1, c2;
    int t_done [3];
    int n_pulses, busy_hi;
    logic b_at_done, b_after;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_freq_bcd", freq_bcd, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'({freq_done, hres_done, duty_done}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // single conversion, latency
    send(0, 32'd12_345_678);
    wait_done(0, 60, c1);
    check("t1_latency", c1, 32'd34);
    check("t1_bcd", freq_bcd, 32'h1234_5678);
    check("t1_ovf", 32'(freq_ovf), 32'd0);
    @(posedge clk); #1;
    check("t1_done_width", 32'(freq_done), 32'd0);

    // saturation then recovery
    send(1, 32'd100_000_000);
    wait_done(1, 60, c1);
    check("t2_sat_bcd", hres_bcd, 32'h9999_9999);
    check("t2_sat_ovf", 32'(hres_ovf), 32'd1);
    send(1, 32'd7);
    wait_done(1, 60, c1);
    check("t2_small_bcd", hres_bcd, 32'h0000_0007);
    check("t2_small_ovf", 32'(hres_ovf), 32'd0);

    // simultaneous burst
    @(negedge clk);
    freq_valid = 1'b1; freq_data = 32'd1;
    hres_valid = 1'b1; hres_data = 32'd2;
    duty_valid = 1'b1; duty_data = 16'd5000;
    @(posedge clk); #1;
    freq_valid = 1'b0; hres_valid = 1'b0; duty_valid = 1'b0;
    t_done = '{-1, -1, -1};
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) if (done_of(c) && t_done[c] < 0) t_done[c] = k;
    end
    check("t3_freq_time", t_done[0], 32'd34);
    check("t3_hres_time", t_done[1], 32'd68);
    check("t3_duty_time", t_done[2], 32'd102);
    check("t3_freq_bcd", freq_bcd, 32'h0000_0001);
    check("t3_hres_bcd", hres_bcd, 32'h0000_0002);
    check("t3_duty_bcd", duty_bcd, 32'h0000_5000);

    // second burst: the model decides the order for either arbitration mode
    @(negedge clk);
    freq_valid = 1'b1; freq_data = 32'd31;
    hres_valid = 1'b1; hres_data = 32'd42;
    duty_valid = 1'b1; duty_data = 16'd53;
    @(posedge clk); #1;
    freq_valid = 1'b0; hres_valid = 1'b0; duty_valid = 1'b0;
    repeat (110) @(posedge clk);
    #1;
    check("t3b_duty_bcd", duty_bcd, 32'h0000_0053);

    // re-trigger during conversion
    send(0, 32'd111);
    repeat (4) @(posedge clk);
    send(0, 32'd222);
    wait_done(0, 60, c1);
    check("t4_first_time", c1, 32'd29);
    check("t4_first_bcd", freq_bcd, 32'h0000_0111);
    wait_done(0, 60, c2);
    check("t4_second_gap", c2, 32'd34);
    check("t4_second_bcd", freq_bcd, 32'h0000_0222);

    // reset mid-conversion with duty pending
    send(2, 32'd1234);
    repeat (10) @(posedge clk);
    send(2, 32'd4321);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_freq_bcd", freq_bcd, 32'h0);
    check("t5_hres_bcd", hres_bcd, 32'h0);
    check("t5_duty_bcd", duty_bcd, 32'h0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ovf", 32'({freq_ovf, hres_ovf, duty_ovf}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n_pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (freq_done || hres_done || duty_done) n_pulses++;
    end
    check("t5_no_done", n_pulses, 32'd0);

    // zero conversion and busy window
    send(2, 32'd0);
    c1 = -1; busy_hi = 0; b_at_done = 1'b1; b_after = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k <= 33 && busy) busy_hi++;
      if (k == 34) b_at_done = busy;
      if (k == 35) b_after = busy;
      if (duty_done && c1 < 0) c1 = k;
    end
    check("t6_time", c1, 32'd34);
    check("t6_bcd", duty_bcd, 32'h0);
    check("t6_busy_cycles", busy_hi, 32'd33);
    check("t6_busy_at_done", 32'(b_at_done), 32'd0);
    check("t6_busy_after", 32'(b_after), 32'd0);

    // pin the model itself
    check("model_enc_a", to_bcd(32'd12_345_678), 32'h1234_5678);
    check("model_enc_b", to_bcd(32'd100_000_000), 32'h9999_9999);

    @(negedge clk);
    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
